// File: rtl/pixel_stream_source.sv
// pixel_stream_source: test-pattern generator for the 12-bit RGB444 pixel stream.
// It emits WIDTH x HEIGHT frames with sop/eop/valid framing and honours ready backpressure.
// Each frame is followed by GAP idle cycles. All outputs are registered.

module pixel_stream_source #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int GAP    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic        ready_in,
   output logic [11:0] data_out,
   output logic        sop_out,
   output logic        eop_out,
   output logic        valid_out,
   output logic        frame_done
);

   localparam int XW    = $clog2(WIDTH);
   localparam int YW    = $clog2(HEIGHT);
   localparam int BAR_W = WIDTH / 8;
   localparam int BW    = $clog2(BAR_W);
   localparam int GW    = $clog2(GAP + 1);

   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);
   localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_GAP
   } state_e;

   state_e         state_q, state_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [3:0]     fc_q, fc_d;
   logic [BW-1:0]  bar_cnt_q, bar_cnt_d;
   logic [2:0]     bar_idx_q, bar_idx_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [1:0]     pat_q, pat_d;
   logic [11:0]    data_q, data_d;
   logic           sop_q, sop_d;
   logic           eop_q, eop_d;
   logic           valid_q, valid_d;
   logic           done_q, done_d;
   logic           start;
   logic           load;

   // Pixel colour for a given position. The bar index is tracked by a counter, so no divider is needed.
   function automatic logic [11:0] pixel(input logic [1:0]    sel,
                                         input logic [XW-1:0] x,
                                         input logic [YW-1:0] y,
                                         input logic [3:0]    fc,
                                         input logic [2:0]    bar);
      case (sel)
         2'd0: return 12'h888;
         2'd1: begin
            case (bar)
               3'd0:    return 12'hFFF;
               3'd1:    return 12'hFF0;
               3'd2:    return 12'h0FF;
               3'd3:    return 12'h0F0;
               3'd4:    return 12'hF0F;
               3'd5:    return 12'hF00;
               3'd6:    return 12'h00F;
               default: return 12'h000;
            endcase
         end
         2'd2:    return {4'(32'(x) >> 4), 4'(32'(y) >> 4), fc};
         default: return (1'(32'(x) >> 4) ^ 1'(32'(y) >> 4)) ? 12'hFFF : 12'h000;
      endcase
   endfunction

   // Next-state logic: frame sequencing, position counters and the registered output values.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      fc_d      = fc_q;
      bar_cnt_d = bar_cnt_q;
      bar_idx_d = bar_idx_q;
      gap_d     = gap_q;
      pat_d     = pat_q;
      data_d    = data_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      valid_d   = valid_q;
      done_d    = 1'b0;
      start     = 1'b0;
      load      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (enable) start = 1'b1;
         end
         S_STREAM: begin
            // valid_q is always set in STREAM, so ready_in alone marks a transfer.
            if (ready_in) begin
               if (x_q == X_LAST) begin
                  if (y_q == Y_LAST) begin
                     state_d = S_GAP;
                     fc_d    = fc_q + 4'd1;
                     done_d  = 1'b1;
                     gap_d   = '0;
                     valid_d = 1'b0;
                     sop_d   = 1'b0;
                     eop_d   = 1'b0;
                     data_d  = '0;
                  end else begin
                     x_d       = '0;
                     y_d       = y_q + YW'(1);
                     bar_cnt_d = '0;
                     bar_idx_d = '0;
                     load      = 1'b1;
                  end
               end else begin
                  x_d = x_q + XW'(1);
                  if (bar_cnt_q == B_LAST) begin
                     bar_cnt_d = '0;
                     bar_idx_d = bar_idx_q + 3'd1;
                  end else begin
                     bar_cnt_d = bar_cnt_q + BW'(1);
                  end
                  load = 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gap_q == G_LAST) begin
               if (enable) start = 1'b1;
               else        state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A frame start samples pattern_sel, which then stays fixed until the next frame.
      if (start) begin
         state_d   = S_STREAM;
         x_d       = '0;
         y_d       = '0;
         bar_cnt_d = '0;
         bar_idx_d = '0;
         pat_d     = pattern_sel;
         load      = 1'b1;
      end

      // Register the pixel for the position being moved to, so outputs change only on an accepted pixel.
      if (load) begin
         valid_d = 1'b1;
         data_d  = pixel(pat_d, x_d, y_d, fc_d, bar_idx_d);
         sop_d   = (x_d == '0) && (y_d == '0);
         eop_d   = (x_d == X_LAST) && (y_d == Y_LAST);
      end
   end

   // State and output registers. Reset aborts the current frame at once, with no eop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         fc_q      <= '0;
         bar_cnt_q <= '0;
         bar_idx_q <= '0;
         gap_q     <= '0;
         pat_q     <= '0;
         data_q    <= '0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register update from the same pre-edge values.
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         fc_q      <= fc_d;
         bar_cnt_q <= bar_cnt_d;
         bar_idx_q <= bar_idx_d;
         gap_q     <= gap_d;
         pat_q     <= pat_d;
         data_q    <= data_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   assign data_out   = data_q;
   assign sop_out    = sop_q;
   assign eop_out    = eop_q;
   assign valid_out  = valid_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source at WIDTH=16, HEIGHT=4, GAP=2.
// Stimulus queues expected frames from an arithmetic pattern model.
// A negedge monitor pops and compares one entry on every transfer and also watches stalls, gaps and frame_done.

module tb_pixel_stream_source;

   localparam int W   = 16;
   localparam int H   = 4;
   localparam int GAP = 2;

   typedef struct packed {
      logic [11:0] data;
      logic        sop;
      logic        eop;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic        ready_in;
   logic [11:0] data_out;
   logic        sop_out;
   logic        eop_out;
   logic        valid_out;
   logic        frame_done;

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   int   fc_model = 0;
   int   xfer_cnt = 0;
   int   sop_cnt  = 0;
   int   eop_cnt  = 0;
   int   fd_cnt   = 0;
   bit   rdy_rand = 1'b0;

   pixel_stream_source #(.WIDTH(W), .HEIGHT(H), .GAP(GAP)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .ready_in    (ready_in),
      .data_out    (data_out),
      .sop_out     (sop_out),
      .eop_out     (eop_out),
      .valid_out   (valid_out),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] bar_colour(input int i);
      case (i)
         0:       return 12'hFFF;
         1:       return 12'hFF0;
         2:       return 12'h0FF;
         3:       return 12'h0F0;
         4:       return 12'hF0F;
         5:       return 12'hF00;
         6:       return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   // Reference model: one whole frame of expected pixels, computed from coordinates.
   task automatic push_frame(input int sel);
      exp_t e;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            case (sel)
               0:       e.data = 12'h888;
               1:       e.data = bar_colour(x / (W / 8));
               2:       e.data = {4'((x >> 4) & 15), 4'((y >> 4) & 15), 4'(fc_model)};
               default: e.data = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
            endcase
            e.sop = (x == 0) && (y == 0);
            e.eop = (x == W - 1) && (y == H - 1);
            exp_q.push_back(e);
         end
      end
      fc_model = (fc_model + 1) % 16;
   endtask

   function automatic int get_cnt(input int which);
      case (which)
         0:       return xfer_cnt;
         1:       return sop_cnt;
         default: return eop_cnt;
      endcase
   endfunction

   // Waits (bounded) until a monitor counter reaches target; returns at posedge+1.
   task automatic wait_cnt(input int which, input int target);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (get_cnt(which) < target && n < 5000);
      check("wait_done", 32'(get_cnt(which) >= target), 32'd1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data"},  32'(data_out),   32'd0);
      check({tag, "_sop"},   32'(sop_out),    32'd0);
      check({tag, "_eop"},   32'(eop_out),    32'd0);
      check({tag, "_valid"}, 32'(valid_out),  32'd0);
      check({tag, "_done"},  32'(frame_done), 32'd0);
   endtask

   // Streams n back-to-back frames of one pattern, then lets the source go idle.
   task automatic run_frames(input int sel, input int n, input bit rnd);
      int x0, f0, s0, e0;
      x0 = xfer_cnt; f0 = fd_cnt; s0 = sop_cnt; e0 = eop_cnt;
      rdy_rand    = rnd;
      pattern_sel = 2'(sel);
      for (int i = 0; i < n; i++) push_frame(sel);
      enable = 1'b1;
      wait_cnt(1, s0 + n);
      enable = 1'b0;
      wait_cnt(2, e0 + n);
      wait_cycles(GAP + 3);
      check("idle_valid", 32'(valid_out), 32'd0);
      check("xfer_count", 32'(xfer_cnt - x0), 32'(W * H * n));
      check("done_count", 32'(fd_cnt - f0), 32'(n));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Ready driver: always ready, or ready about 75% of cycles.
   initial begin
      ready_in = 1'b1;
      forever begin
         @(posedge clk); #1;
         ready_in = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Monitor: scoreboard pop on transfer, stall stability, gap length and frame_done timing.
   initial begin
      exp_t        e;
      bit          in_gap = 1'b0;
      int          idle_run = 0;
      logic        en_at_end = 1'b0;
      bit          expect_fd = 1'b0;
      bit          stall_prev = 1'b0;
      logic [13:0] held = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            in_gap     = 1'b0;
            expect_fd  = 1'b0;
            stall_prev = 1'b0;
         end else begin
            if (frame_done || expect_fd) begin
               check("frame_done", 32'(frame_done), 32'(expect_fd));
               if (frame_done) fd_cnt++;
            end
            expect_fd = 1'b0;

            if (in_gap) begin
               if (idle_run == GAP) begin
                  check("gap_restart", 32'(valid_out), 32'(en_at_end));
                  in_gap = 1'b0;
               end else if (valid_out) begin
                  check("gap_short", 32'(idle_run), 32'(GAP));
                  in_gap = 1'b0;
               end else begin
                  idle_run++;
                  if (idle_run == GAP) en_at_end = enable;
               end
            end

            if (stall_prev) begin
               check("stall_valid", 32'(valid_out), 32'd1);
               check("stall_stable", 32'({data_out, sop_out, eop_out}), 32'(held));
            end
            stall_prev = valid_out && !ready_in;
            held       = {data_out, sop_out, eop_out};

            if (valid_out && ready_in) begin
               xfer_cnt++;
               if (sop_out) sop_cnt++;
               if (eop_out) eop_cnt++;
               if (exp_q.size() == 0) begin
                  check("unexpected_xfer", 32'd0, 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  check("pix_data", 32'(data_out), 32'(e.data));
                  check("pix_sop",  32'(sop_out),  32'(e.sop));
                  check("pix_eop",  32'(eop_out),  32'(e.eop));
               end
               if (eop_out) begin
                  in_gap    = 1'b1;
                  idle_run  = 0;
                  expect_fd = 1'b1;
               end
            end
         end
      end
   end

   // Stimulus.
   initial begin
      int b;
      reset       = 1'b0;
      enable      = 1'b0;
      pattern_sel = 2'd0;
      wait_cycles(3);
      check_outputs_zero("reset");
      reset = 1'b1;
      wait_cycles(3);
      check("idle_after_reset", 32'(valid_out), 32'd0);

      // 1: grey frame, full throughput.
      run_frames(0, 1, 1'b0);
      // 2: colour bars, full throughput.
      run_frames(1, 1, 1'b0);
      // 3: checkerboard with random backpressure.
      run_frames(3, 1, 1'b1);

      // 4: enable dropped and pattern switched mid-frame.
      rdy_rand    = 1'b1;
      b           = xfer_cnt;
      pattern_sel = 2'd1;
      push_frame(1);
      enable = 1'b1;
      wait_cnt(0, b + 20);
      enable = 1'b0;
      wait_cnt(0, b + 30);
      pattern_sel = 2'd3;
      wait_cnt(0, b + W * H);
      wait_cycles(GAP + 3);
      for (int i = 0; i < 5; i++) begin
         check("stays_idle", 32'(valid_out), 32'd0);
         wait_cycles(1);
      end
      check("partial_frame_count", 32'(xfer_cnt - b), 32'(W * H));
      run_frames(3, 1, 1'b0);

      // 5: gradient over 17 back-to-back frames from a fresh frame counter.
      reset = 1'b0;
      wait_cycles(2);
      reset    = 1'b1;
      fc_model = 0;
      wait_cycles(2);
      run_frames(2, 17, 1'b0);

      // 6: asynchronous reset mid-line while valid is high.
      rdy_rand    = 1'b1;
      pattern_sel = 2'd3;
      b           = xfer_cnt;
      push_frame(3);
      enable = 1'b1;
      wait_cnt(0, b + 21);
      check("valid_before_abort", 32'(valid_out), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check_outputs_zero("abort");
      exp_q.delete();
      fc_model = 0;
      enable   = 1'b0;
      wait_cycles(3);
      check_outputs_zero("abort_held");
      reset = 1'b1;
      run_frames(0, 1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
